// File: rtl/cbus_ram_responder.sv
// ============================================================================
// Module   : cbus_ram_responder (with package cbus_pkg)
// Purpose  : Burst cache-bus responder serving FIXED/INCR/WRAP bursts from a
//            64-bit-wide internal RAM with byte-strobed writes.
// Option   : CBUS_RESP_STALL_EN -- LFSR-driven back-pressure on `ready`.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_pkg;
  // len encodes beats-1; size encodes log2(bytes per beat)
  localparam logic [7:0] MLEN1  = 8'd0;
  localparam logic [7:0] MLEN2  = 8'd1;
  localparam logic [7:0] MLEN4  = 8'd3;
  localparam logic [7:0] MLEN8  = 8'd7;
  localparam logic [7:0] MLEN16 = 8'd15;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  localparam logic [1:0] CBUS_FIXED = 2'd0;
  localparam logic [1:0] CBUS_INCR  = 2'd1;
  localparam logic [1:0] CBUS_WRAP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [2:0]        size_q, size_d;
  logic [63:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic [63:0]       mem [MEM_WORDS];

  logic              ready;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [63:0]       step;
  logic [63:0]       wrap_mask;
  logic [63:0]       addr_nxt;

`ifdef CBUS_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16/14/13/11, free-running from reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign ready = (state_q == S_BURST) && lfsr_q[0];
`else
  assign ready = (state_q == S_BURST);
`endif

  assign idx       = addr_q[IDX_W+2:3];
  assign step      = 64'd1 << size_q;
  assign wrap_mask = (({56'd0, len_q} + 64'd1) << size_q) - 64'd1;

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      CBUS_INCR: addr_nxt = addr_q + step;
      CBUS_WRAP: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:   addr_nxt = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 64'd0;
      len_q      <= 8'd0;
      burst_q    <= 2'd0;
      beat_q     <= 8'd0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    case (state_q)
      S_IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          size_d     = creq.size;
          addr_d     = creq.addr;
          len_d      = creq.len;
          burst_d    = creq.burst;
          beat_d     = 8'd0;
          lat_d      = LAT_W'(LATENCY - 1);
          state_d    = (LATENCY == 1) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        // Entering BURST as the counter hits zero places the first ready
        // beat LATENCY cycles after the accepting edge.
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
          if (lat_q <= LAT_W'(1)) begin
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (ready) begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_nxt;
          if (beat_q == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // An aborting beat (valid dropped mid-burst) is not written.
  assign wr_en = ready && creq.valid && is_write_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (creq.strobe[i]) begin
          mem[idx][8*i +: 8] <= creq.data[8*i +: 8];
        end
      end
    end
  end

  assign cresp.ready = ready;
  assign cresp.last  = ready && (beat_q == len_q);
  assign cresp.data  = (ready && !is_write_q) ? mem[idx] : 64'd0;

endmodule

`default_nettype wire

// File: doc/cbus_ram_responder.md
# cbus_ram_responder

Responder (worker) end of the simplified burst cache bus: accepts `cbus_req_t` transactions from a cache or bus arbiter, serves them beat by beat from an internal 64-bit-wide RAM, and drives `cbus_resp_t`. It stands in for the AXI memory side in simulation and on-chip BRAM builds, and supports FIXED, INCR and WRAP bursts with byte-strobed writes.

## Interface
- `MEM_WORDS`, 4096: RAM depth in 64-bit words; power of two.
- `LATENCY`, 2: cycles from the accepting edge to the first `ready` beat; must be ≥1.
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `creq` in `cbus_req_t`: request; held stable by the master from acceptance until the beat carrying `last`, except `data`/`strobe`, which change per write beat.
- `cresp` out `cbus_resp_t`: `ready` (beat completes this cycle), `last` (final beat), `data` (read data).

## Operation
- States: IDLE, WAIT, BURST, DONE.
- IDLE: on a rising edge with `creq.valid`=1, latch `is_write`, `size`, `addr`, `len`, `burst`; beat counter := 0; latency counter := LATENCY-1; go to WAIT, or BURST if LATENCY=1.
- WAIT: decrement the latency counter; at 0 go to BURST.
- BURST: `ready`=1 (subject to Configuration). `last` = `ready` && beat == latched `len`.
  - Read: `data` = mem[idx], combinational from the current beat address.
  - Write: on the edge, each byte i with `strobe[i]`=1 writes `creq.data[8i+7:8i]` into mem[idx].
  - After each beat: beat counter +1 and the address advances. On the `last` beat, go to DONE.
- DONE: one cycle; `creq.valid` is ignored so the master can drop it; then IDLE.
- Word index: idx = addr[$clog2(MEM_WORDS)+2:3]. Higher address bits are ignored, so out-of-range addresses alias modulo the RAM size.
- Address step: step = 1<<size bytes.
  - FIXED: address unchanged.
  - INCR: addr + step, full 64-bit add, no boundary check.
  - WRAP: with mask = (len+1)*step-1, next = (addr & ~mask) | ((addr+step) & mask).
- Sub-word sizes: data is always the whole 64-bit word at idx; the master selects lanes with `strobe` on writes and extracts bytes itself on reads.
- `creq.valid` low during WAIT/BURST is a protocol violation. The responder aborts to IDLE on the next edge; beats already written stay written.
- Reset: state := IDLE, counters := 0. RAM contents are not cleared.

## Timing
- Reset values: `cresp.ready`=0, `cresp.last`=0, `cresp.data`=0.
- `data` is 0 whenever `ready`=0 or the transaction is a write.
- First beat is `ready` exactly LATENCY cycles after the accepting edge. Without stalls, beats are back to back: a transaction of len+1 beats occupies LATENCY+len+1 cycles plus one DONE cycle.
- Earliest next acceptance: 2 edges after the `last` edge.
- Single-beat transaction (`len`=MLEN1): `ready` and `last` are asserted in the same cycle.
- Write data is visible to a read beat of the following transaction, with no bypass hazard.

## Configuration
- `CBUS_RESP_STALL_EN` defined: a 16-bit LFSR (seed 16'hACE1, reset to seed, steps every cycle) gates `ready` in BURST. `ready` = state==BURST && lfsr[0]. Beats, address and counters advance only on cycles with `ready`=1. This exercises master back-pressure tolerance.
- `CBUS_RESP_STALL_EN` undefined: `ready` = state==BURST; the LFSR is not instantiated.

## Test plan
- INCR write then read: write MLEN4, MSIZE8, addr 0x80000100, data 0x11..,0x22..,0x33..,0x44.. with full strobe → 4 `ready` beats, `last` on the 4th. A subsequent INCR read of the same region returns the 4 words in order, first `ready` LATENCY cycles after acceptance.
- WRAP read: preload words 0–15 with values 0..15, then WRAP MLEN16, MSIZE8, addr 0x58 → data sequence 11,12,13,14,15,0,…,10.
- Strobed write: write 0xFFFF_FFFF_FFFF_FFFF with strobe 0x0F to a word holding 0 → reads back 0x0000_0000_FFFF_FFFF.
- FIXED / single-beat:
  - FIXED MLEN4 write to one address → the word holds the 4th beat's data.
  - MLEN1 read → `ready` and `last` in the same cycle; no acceptance in the DONE cycle even if `valid` is held.
- Reset mid-burst: assert `resetn`=0 during beat 3 of an MLEN16 read → `ready`/`last`/`data` go to 0 immediately. After release, a new request is accepted normally and earlier RAM writes are preserved.
- Stall build (`CBUS_RESP_STALL_EN`): MLEN16 INCR read → exactly 16 `ready` beats in the correct order and exactly one `last`, with gaps matching the LFSR.
